oam_dma_ctrl: RTL and testbench
===============================

# oam_dma_ctrl

Parametrised sprite-DMA engine for the NES CPU subsystem. It snoops CPU writes for the DMA trigger address, halts the CPU through its ready line, and copies a block of LEN bytes from CPU address space, page number times LEN, into OAM. It sits beside the CPU core between the CPU bus and WRAM/PPU OAM. While busy it owns the memory bus. It generalises the fixed 256-byte OAM DMA with configurable length, widths, trigger address, start offset, optional parity alignment and a completion pulse.

## Interface
Parameters:
- ADDR_W, 16, CPU/memory address width
- DATA_W, 8, data width; page number width
- LEN, 256, bytes per transfer; power of two, 2..256; IDX_W = $clog2(LEN)
- TRIG_ADDR, 16'h4014, CPU write address that starts a transfer
- ALIGN, 1, 1 = reads only on even parity cycles; 0 = no alignment cycle

Ports:
- clk  in  1  system clock (single clock domain)
- reset  in  1  synchronous, active-high reset
- cpu_addr  in  ADDR_W  CPU address bus
- cpu_data_out  in  DATA_W  CPU write data
- cpu_we  in  1  CPU write strobe, active high, one cycle per write
- cpu_rdy  out  1  CPU ready; 0 halts CPU
- mem_addr  out  ADDR_W  DMA read address; valid when mem_rd=1
- mem_rd  out  1  DMA read strobe; memory returns data exactly 1 cycle later
- mem_data_in  in  DATA_W  memory read data
- oam_base  in  IDX_W  OAM start offset; sampled at trigger
- oam_addr  out  IDX_W  OAM write address
- oam_data  out  DATA_W  OAM write data
- oam_we  out  1  OAM write enable
- oam_dma  out  1  high while a transfer owns the bus, HALT through last WRITE
- dma_done  out  1  one-cycle pulse after the last OAM write

## Operation
- Trigger: cpu_we=1 and cpu_addr==TRIG_ADDR while in IDLE. Latch page=cpu_data_out, base=oam_base, idx=0.
- Triggers while not IDLE are ignored. Writes to any other address have no effect.
- Parity flop cyc: reset 0, toggles every cycle, free-running.
- States:
  - IDLE: wait for a trigger.
  - HALT: one cycle, lets the CPU's current access finish.
  - ALIGN: one dead cycle.
  - READ: drive mem_rd=1, mem_addr = (({page, IDX_W'b0}) + idx) truncated to ADDR_W.
  - WRITE: drive oam_we=1, oam_data=mem_data_in, oam_addr=(base+idx) mod 2^IDX_W; then idx+1.
- Transitions:
  - IDLE→HALT on trigger.
  - HALT→READ if ALIGN=0 or cyc==1 in the HALT cycle; otherwise HALT→ALIGN→READ.
  - READ→WRITE always.
  - WRITE→READ if idx != LEN-1; otherwise WRITE→IDLE with dma_done=1 on the next cycle.
- Result: with ALIGN=1, READ cycles always have cyc==0.
- oam_addr wraps modulo LEN. The idx counter never exceeds LEN-1. The memory address adds without carry beyond ADDR_W.
- cpu_rdy=0 and oam_dma=1 in HALT, ALIGN, READ and WRITE. Otherwise cpu_rdy=1 and oam_dma=0.
- Reset mid-transfer: next cycle in IDLE, all outputs at reset values, partial copy abandoned, no dma_done.

## Timing
- Reset values:
  - cpu_rdy=1
  - mem_rd=0, oam_we=0, oam_dma=0, dma_done=0
  - mem_addr=0, oam_addr=0, oam_data=0
  - state IDLE, cyc=0
- Trigger write in cycle T: HALT in T+1, cpu_rdy low from T+1.
- Busy length: 1+2*LEN cycles without alignment, 2+2*LEN with it (513/514 for LEN=256).
- Read in cycle R: the matching oam_we is in R+1, carrying mem_data_in sampled in R+1.
- dma_done is high in the first IDLE cycle; cpu_rdy=1 in that same cycle.
- A trigger coincident with dma_done (first IDLE cycle) is accepted.
- Outputs are registered, except oam_data, which passes mem_data_in through combinationally during WRITE.

## Test plan
- LEN=256, trigger write 8'h02, HALT cycle at cyc=1:
  - 513 busy cycles.
  - mem_addr 16'h0200..16'h02FF in order.
  - 256 OAM writes, oam_addr 0..255, data matching a memory model.
  - dma_done one pulse.
- Same transfer with HALT cycle at cyc=0: one ALIGN cycle, 514 busy cycles, every mem_rd on cyc==0. With ALIGN=0: always 513.
- oam_base=8'hF0, page 8'h03: first write to oam_addr 8'hF0, byte 16 to 8'h00 (wrap), last to 8'hEF.
- Second trigger (8'h05) during a busy transfer: ignored, addresses stay on the original page. A write to 16'h4015 while idle produces no activity.
- Reset asserted at the 100th WRITE: next cycle cpu_rdy=1, oam_we=0, oam_dma=0, no dma_done. A following trigger restarts from idx 0.
- LEN=4, TRIG_ADDR=16'h4020, page 8'h01:
  - mem_addr 16'h0004..16'h0007.
  - 9 or 10 busy cycles.
  - oam_addr 2-bit wrap from oam_base=2'd3: 3, 0, 1, 2.

Source files
------------

// File: rtl/oam_dma_ctrl.sv
`default_nettype none
// ============================================================================
// oam_dma_ctrl : sprite DMA engine, halts the CPU and copies LEN bytes to OAM
// Rev 1.0
// ============================================================================
module oam_dma_ctrl #(
   parameter int                ADDR_W    = 16,
   parameter int                DATA_W    = 8,
   parameter int                LEN       = 256,
   parameter logic [ADDR_W-1:0] TRIG_ADDR = 16'h4014,
   parameter int                ALIGN     = 1,
   localparam int               IDX_W     = $clog2(LEN)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_data_out,
   input  logic              cpu_we,
   output logic              cpu_rdy,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_rd,
   input  logic [DATA_W-1:0] mem_data_in,
   input  logic [IDX_W-1:0]  oam_base,
   output logic [IDX_W-1:0]  oam_addr,
   output logic [DATA_W-1:0] oam_data,
   output logic              oam_we,
   output logic              oam_dma,
   output logic              dma_done
);

   localparam int               SUM_W = (ADDR_W > DATA_W + IDX_W) ? ADDR_W : DATA_W + IDX_W;
   localparam logic [IDX_W-1:0] LAST  = IDX_W'(LEN - 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_HALT  = 3'd1,
      S_ALIGN = 3'd2,
      S_READ  = 3'd3,
      S_WRITE = 3'd4
   } state_t;

   state_t            state;
   logic              cyc;
   logic [DATA_W-1:0] page;
   logic [IDX_W-1:0]  base;
   logic [IDX_W-1:0]  idx;
   logic [IDX_W-1:0]  idx_nxt;
   logic              trigger;

   assign trigger = cpu_we && (cpu_addr == TRIG_ADDR);
   assign idx_nxt = idx + IDX_W'(1);

   // Source address is page*LEN + idx, computed wide enough and then cut to ADDR_W.
   function automatic logic [ADDR_W-1:0] rd_addr(input logic [DATA_W-1:0] pg,
                                                 input logic [IDX_W-1:0]  ix);
      logic [SUM_W-1:0] full;
      full = SUM_W'({pg, {IDX_W{1'b0}}}) + SUM_W'(ix);
      return full[ADDR_W-1:0];
   endfunction

   // Memory answers one cycle after the read, so the data is live during WRITE.
   assign oam_data = (state == S_WRITE) ? mem_data_in : '0;

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= S_IDLE;
         cyc      <= 1'b0;
         page     <= '0;
         base     <= '0;
         idx      <= '0;
         cpu_rdy  <= 1'b1;
         mem_rd   <= 1'b0;
         mem_addr <= '0;
         oam_we   <= 1'b0;
         oam_addr <= '0;
         oam_dma  <= 1'b0;
         dma_done <= 1'b0;
      end else begin
         cyc      <= ~cyc;
         dma_done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (trigger) begin
                  state   <= S_HALT;
                  page    <= cpu_data_out;
                  base    <= oam_base;
                  idx     <= '0;
                  cpu_rdy <= 1'b0;
                  oam_dma <= 1'b1;
               end
            end
            S_HALT: begin
               // With alignment, reads must land on even cycles: skip ahead only when next is even.
               if ((ALIGN == 0) || cyc) begin
                  state    <= S_READ;
                  mem_rd   <= 1'b1;
                  mem_addr <= rd_addr(page, idx);
               end else begin
                  state <= S_ALIGN;
               end
            end
            S_ALIGN: begin
               state    <= S_READ;
               mem_rd   <= 1'b1;
               mem_addr <= rd_addr(page, idx);
            end
            S_READ: begin
               state    <= S_WRITE;
               mem_rd   <= 1'b0;
               oam_we   <= 1'b1;
               oam_addr <= base + idx;
            end
            S_WRITE: begin
               oam_we <= 1'b0;
               if (idx == LAST) begin
                  state    <= S_IDLE;
                  cpu_rdy  <= 1'b1;
                  oam_dma  <= 1'b0;
                  dma_done <= 1'b1;
               end else begin
                  state    <= S_READ;
                  idx      <= idx_nxt;
                  mem_rd   <= 1'b1;
                  mem_addr <= rd_addr(page, idx_nxt);
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_oam_dma_ctrl.sv
`default_nettype none
// ============================================================================
// tb_oam_dma_ctrl : randomized checks of oam_dma_ctrl against a transfer model
// Rev 1.0
// ============================================================================
module tb_oam_dma_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] cpu_addr;
   logic [7:0]  cpu_data_out;
   logic        cpu_we;
   logic [7:0]  oam_base_w;
   logic [1:0]  oam_base_s;

   // a: LEN 256 aligned, c: LEN 256 unaligned, b: LEN 4 at 0x4020 aligned
   logic        cpu_rdy_a, mem_rd_a, oam_we_a, oam_dma_a, dma_done_a;
   logic [15:0] mem_addr_a;
   logic [7:0]  mem_data_a, oam_addr_a, oam_data_a;
   logic        cpu_rdy_c, mem_rd_c, oam_we_c, oam_dma_c, dma_done_c;
   logic [15:0] mem_addr_c;
   logic [7:0]  mem_data_c, oam_addr_c, oam_data_c;
   logic        cpu_rdy_b, mem_rd_b, oam_we_b, oam_dma_b, dma_done_b;
   logic [15:0] mem_addr_b;
   logic [7:0]  mem_data_b, oam_data_b;
   logic [1:0]  oam_addr_b;

   logic [7:0]  mem [0:65535];
   logic        tb_cyc;

   int n_tests = 0;
   int n_fail  = 0;

   int rd_a[$], wra_addr[$], wra_data[$];
   int rd_c[$], wrc_addr[$], wrc_data[$];
   int rd_b[$], wrb_addr[$], wrb_data[$];
   int busy_a = 0, done_a = 0, parv_a = 0;
   int busy_c = 0, done_c = 0;
   int busy_b = 0, done_b = 0, parv_b = 0;

   always #5 clk = ~clk;

   oam_dma_ctrl #(.LEN(256), .TRIG_ADDR(16'h4014), .ALIGN(1)) dut_a (
      .clk(clk), .reset(reset), .cpu_addr(cpu_addr), .cpu_data_out(cpu_data_out), .cpu_we(cpu_we),
      .cpu_rdy(cpu_rdy_a), .mem_addr(mem_addr_a), .mem_rd(mem_rd_a), .mem_data_in(mem_data_a),
      .oam_base(oam_base_w), .oam_addr(oam_addr_a), .oam_data(oam_data_a), .oam_we(oam_we_a),
      .oam_dma(oam_dma_a), .dma_done(dma_done_a));

   oam_dma_ctrl #(.LEN(256), .TRIG_ADDR(16'h4014), .ALIGN(0)) dut_c (
      .clk(clk), .reset(reset), .cpu_addr(cpu_addr), .cpu_data_out(cpu_data_out), .cpu_we(cpu_we),
      .cpu_rdy(cpu_rdy_c), .mem_addr(mem_addr_c), .mem_rd(mem_rd_c), .mem_data_in(mem_data_c),
      .oam_base(oam_base_w), .oam_addr(oam_addr_c), .oam_data(oam_data_c), .oam_we(oam_we_c),
      .oam_dma(oam_dma_c), .dma_done(dma_done_c));

   oam_dma_ctrl #(.LEN(4), .TRIG_ADDR(16'h4020), .ALIGN(1)) dut_b (
      .clk(clk), .reset(reset), .cpu_addr(cpu_addr), .cpu_data_out(cpu_data_out), .cpu_we(cpu_we),
      .cpu_rdy(cpu_rdy_b), .mem_addr(mem_addr_b), .mem_rd(mem_rd_b), .mem_data_in(mem_data_b),
      .oam_base(oam_base_s), .oam_addr(oam_addr_b), .oam_data(oam_data_b), .oam_we(oam_we_b),
      .oam_dma(oam_dma_b), .dma_done(dma_done_b));

   // Memory returns data one cycle after a read; otherwise the bus carries junk.
   always @(posedge clk) begin
      mem_data_a <= mem_rd_a ? mem[mem_addr_a] : 8'($urandom);
      mem_data_c <= mem_rd_c ? mem[mem_addr_c] : 8'($urandom);
      mem_data_b <= mem_rd_b ? mem[mem_addr_b] : 8'($urandom);
      tb_cyc     <= reset ? 1'b0 : ~tb_cyc;
   end

   always @(negedge clk) begin
      if (oam_dma_a) busy_a++;
      if (dma_done_a) done_a++;
      if (mem_rd_a) begin rd_a.push_back(int'(mem_addr_a)); if (tb_cyc) parv_a++; end
      if (oam_we_a) begin wra_addr.push_back(int'(oam_addr_a)); wra_data.push_back(int'(oam_data_a)); end
      if (oam_dma_c) busy_c++;
      if (dma_done_c) done_c++;
      if (mem_rd_c) rd_c.push_back(int'(mem_addr_c));
      if (oam_we_c) begin wrc_addr.push_back(int'(oam_addr_c)); wrc_data.push_back(int'(oam_data_c)); end
      if (oam_dma_b) busy_b++;
      if (dma_done_b) done_b++;
      if (mem_rd_b) begin rd_b.push_back(int'(mem_addr_b)); if (tb_cyc) parv_b++; end
      if (oam_we_b) begin wrb_addr.push_back(int'(oam_addr_b)); wrb_data.push_back(int'(oam_data_b)); end
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Issue a trigger write timed so the HALT cycle sees parity hp.
   task automatic trig(input logic [15:0] a, input logic [7:0] d, input bit hp);
      @(posedge clk); #1;
      if (tb_cyc == hp) begin @(posedge clk); #1; end
      cpu_addr = a; cpu_data_out = d; cpu_we = 1'b1;
      @(posedge clk); #1;
      cpu_we = 1'b0; cpu_addr = 16'($urandom); cpu_data_out = 8'($urandom);
   endtask

   task automatic big_xfer(input logic [7:0] page, input logic [7:0] base, input bit hp, input bit retrig);
      int ra0, wa0, ba0, da0, pa0, rc0, wc0, bc0, dc0, ea;
      ra0 = rd_a.size(); wa0 = wra_addr.size(); ba0 = busy_a; da0 = done_a; pa0 = parv_a;
      rc0 = rd_c.size(); wc0 = wrc_addr.size(); bc0 = busy_c; dc0 = done_c;
      oam_base_w = base;
      trig(16'h4014, page, hp);
      oam_base_w = 8'($urandom);
      if (retrig) begin
         repeat (20) @(posedge clk);
         #1 cpu_addr = 16'h4014; cpu_data_out = 8'h05; cpu_we = 1'b1;
         @(posedge clk); #1 cpu_we = 1'b0;
      end
      for (int i = 0; i < 1200 && !(done_a > da0 && done_c > dc0); i++) begin @(negedge clk); #1; end
      repeat (3) @(negedge clk);
      #1;
      check("busy_a", busy_a - ba0, hp ? 513 : 514);
      check("busy_c", busy_c - bc0, 513);
      check("done_a", done_a - da0, 1);
      check("done_c", done_c - dc0, 1);
      check("par_a", parv_a - pa0, 0);
      check("nrd_a", rd_a.size() - ra0, 256);
      check("nwr_a", wra_addr.size() - wa0, 256);
      check("nrd_c", rd_c.size() - rc0, 256);
      check("nwr_c", wrc_addr.size() - wc0, 256);
      for (int k = 0; k < 256; k++) begin
         ea = (int'(page) * 256 + k) % 65536;
         check($sformatf("rd_a[%0d]", k),  (ra0 + k < rd_a.size())     ? rd_a[ra0 + k]     : -1, ea);
         check($sformatf("wa_a[%0d]", k),  (wa0 + k < wra_addr.size()) ? wra_addr[wa0 + k] : -1, (int'(base) + k) % 256);
         check($sformatf("wd_a[%0d]", k),  (wa0 + k < wra_data.size()) ? wra_data[wa0 + k] : -1, int'(mem[ea]));
         check($sformatf("rd_c[%0d]", k),  (rc0 + k < rd_c.size())     ? rd_c[rc0 + k]     : -1, ea);
         check($sformatf("wa_c[%0d]", k),  (wc0 + k < wrc_addr.size()) ? wrc_addr[wc0 + k] : -1, (int'(base) + k) % 256);
         check($sformatf("wd_c[%0d]", k),  (wc0 + k < wrc_data.size()) ? wrc_data[wc0 + k] : -1, int'(mem[ea]));
      end
   endtask

   task automatic small_xfer(input logic [7:0] page, input logic [1:0] base, input bit hp, input bit chain);
      int rb0, wb0, bb0, db0, pb0, n, exp_busy, ea, j;
      bit hp2;
      rb0 = rd_b.size(); wb0 = wrb_addr.size(); bb0 = busy_b; db0 = done_b; pb0 = parv_b;
      oam_base_s = base;
      trig(16'h4020, page, hp);
      n = 1;
      exp_busy = hp ? 9 : 10;
      if (chain) begin
         for (int i = 0; i < 100 && (wrb_addr.size() - wb0) < 4; i++) begin @(negedge clk); #1; end
         @(posedge clk); #1;
         check("b_done_coincide", dma_done_b, 1);
         hp2 = ~tb_cyc;
         cpu_addr = 16'h4020; cpu_data_out = page; cpu_we = 1'b1;
         @(posedge clk); #1 cpu_we = 1'b0;
         n = 2;
         exp_busy += hp2 ? 9 : 10;
      end
      for (int i = 0; i < 200 && (done_b - db0) < n; i++) begin @(negedge clk); #1; end
      repeat (2) @(negedge clk);
      #1;
      check("busy_b", busy_b - bb0, exp_busy);
      check("done_b", done_b - db0, n);
      check("par_b", parv_b - pb0, 0);
      check("nrd_b", rd_b.size() - rb0, 4 * n);
      for (int t = 0; t < n; t++) begin
         for (int k = 0; k < 4; k++) begin
            j  = t * 4 + k;
            ea = (int'(page) * 4 + k) % 65536;
            check($sformatf("rd_b[%0d]", j), (rb0 + j < rd_b.size())     ? rd_b[rb0 + j]     : -1, ea);
            check($sformatf("wa_b[%0d]", j), (wb0 + j < wrb_addr.size()) ? wrb_addr[wb0 + j] : -1, (int'(base) + k) % 4);
            check($sformatf("wd_b[%0d]", j), (wb0 + j < wrb_data.size()) ? wrb_data[wb0 + j] : -1, int'(mem[ea]));
         end
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int wa0, da0, ba0, bb0, bc0, ra0;
      for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
      reset = 1'b1; cpu_we = 1'b0; cpu_addr = '0; cpu_data_out = '0;
      oam_base_w = '0; oam_base_s = '0;
      repeat (4) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk); #1;
      check("rst_cpu_rdy", cpu_rdy_a, 1);
      check("rst_mem_rd", mem_rd_a, 0);
      check("rst_oam_we", oam_we_a, 0);
      check("rst_oam_dma", oam_dma_a, 0);
      check("rst_dma_done", dma_done_a, 0);
      check("rst_mem_addr", mem_addr_a, 0);
      check("rst_oam_addr", oam_addr_a, 0);
      check("rst_oam_data", oam_data_a, 0);

      big_xfer(8'h02, 8'h00, 1'b1, 1'b1);
      big_xfer(8'h02, 8'h00, 1'b0, 1'b0);
      big_xfer(8'h03, 8'hF0, 1'($urandom), 1'b0);

      // A write to a neighbouring register must not start anything.
      ra0 = rd_a.size(); ba0 = busy_a; bb0 = busy_b; bc0 = busy_c;
      @(posedge clk); #1 cpu_addr = 16'h4015; cpu_data_out = 8'h02; cpu_we = 1'b1;
      @(posedge clk); #1 cpu_we = 1'b0;
      repeat (10) @(negedge clk);
      #1;
      check("idle_busy_a", busy_a - ba0, 0);
      check("idle_busy_b", busy_b - bb0, 0);
      check("idle_busy_c", busy_c - bc0, 0);
      check("idle_rd_a", rd_a.size() - ra0, 0);
      check("idle_cpu_rdy", cpu_rdy_a, 1);

      // Reset in the 100th WRITE abandons the copy.
      wa0 = wra_addr.size(); da0 = done_a;
      trig(16'h4014, 8'($urandom), 1'($urandom));
      for (int i = 0; i < 1000 && (wra_addr.size() - wa0) < 100; i++) begin @(negedge clk); #1; end
      check("w100_we", oam_we_a, 1);
      reset = 1'b1;
      @(posedge clk); #1 reset = 1'b0;
      @(negedge clk); #1;
      check("rst_mid_cpu_rdy", cpu_rdy_a, 1);
      check("rst_mid_oam_we", oam_we_a, 0);
      check("rst_mid_oam_dma", oam_dma_a, 0);
      check("rst_mid_dma_done", dma_done_a, 0);
      check("rst_mid_mem_rd", mem_rd_a, 0);
      repeat (600) @(negedge clk);
      #1;
      check("rst_mid_no_done", done_a - da0, 0);
      check("rst_mid_nwr", wra_addr.size() - wa0, 100);
      big_xfer(8'($urandom), 8'($urandom), 1'($urandom), 1'b0);
      big_xfer(8'hFF, 8'($urandom), 1'($urandom), 1'b0);

      small_xfer(8'h01, 2'd3, 1'b1, 1'b0);
      small_xfer(8'h01, 2'd3, 1'b0, 1'b0);
      small_xfer(8'($urandom), 2'($urandom), 1'($urandom), 1'b1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
